// File: rtl/soc_ram_dmem_pl.sv
// Single-port data RAM for the SoC data bus: byte-enabled writes, 1..3 cycle pipelined reads,
// optional post-reset clear sweep, and region-miss error reporting on a valid/ack interface.
module soc_ram_dmem_pl #(
    parameter logic [31:0]             p_addr_base      = 32'h1000_0000,
    parameter logic [31:0]             p_addr_mask      = 32'hffff_f000,
    parameter int unsigned             p_data_width     = 32,
    parameter int unsigned             p_depth_pw2      = 13,
    parameter int unsigned             p_rd_latency     = 1,
    parameter bit                      p_clear_on_reset = 1'b1,
    parameter logic [p_data_width-1:0] p_init_val       = '0,
    localparam int unsigned            Lsb              = (p_data_width == 64) ? 3 : 2,
    localparam int unsigned            Nb               = p_data_width / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [31:Lsb]           i_addr,
    input  logic [Nb-1:0]           i_be,
    input  logic                    i_wr_en,
    input  logic [p_data_width-1:0] i_wr_data,
    input  logic                    i_rd_en,
    output logic [p_data_width-1:0] o_rd_data,
    output logic                    o_busy,
    output logic                    o_ack,
    output logic                    o_err
);

    localparam int unsigned Depth = 2 ** p_depth_pw2;
    localparam int unsigned Last  = p_rd_latency - 1;

    typedef enum logic [1:0] {StRst, StClear, StReady} state_e;

    state_e                   state_q, state_d;
    logic [p_depth_pw2-1:0]   clr_cnt_q, clr_cnt_d;
    logic [p_data_width-1:0]  mem [Depth];

    logic [31:0]              byte_addr;
    logic [p_depth_pw2-1:0]   idx;
    logic                     hit, ready, clearing;
    logic                     wr_acc, rd_acc;

    logic                     wr_ack_q, wr_err_q;
    logic [Last:0]            rd_vld_q, rd_err_q;
    logic [p_data_width-1:0]  rd_data_q [p_rd_latency];
    logic [p_data_width-1:0]  rd_hold_q;
    logic                     rd_done;

    assign byte_addr = {i_addr, {Lsb{1'b0}}};
    assign idx       = i_addr[Lsb+p_depth_pw2-1:Lsb];
    assign hit       = (byte_addr & p_addr_mask) == (p_addr_base & p_addr_mask);
    assign ready     = (state_q == StReady);
    assign clearing  = (state_q == StClear);
    // Write has priority; a simultaneous read is dropped and flagged via the write's error.
    assign wr_acc    = ready & i_wr_en;
    assign rd_acc    = ready & i_rd_en & ~i_wr_en;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StRst: begin
                clr_cnt_d = '0;
                state_d   = p_clear_on_reset ? StClear : StReady;
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = StReady;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StRst;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage has no reset; contents survive reset unless swept.
    always_ff @(posedge i_clk) begin
        if (clearing) begin
            mem[clr_cnt_q] <= p_init_val;
        end else if (wr_acc && hit) begin
            for (int k = 0; k < Nb; k++) begin
                if (i_be[k]) begin
                    mem[idx][8*k +: 8] <= i_wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_vld_q  <= '0;
            rd_err_q  <= '0;
            rd_hold_q <= '0;
            for (int i = 0; i < p_rd_latency; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            wr_ack_q     <= wr_acc;
            wr_err_q     <= wr_acc & (~hit | i_rd_en);
            rd_vld_q[0]  <= rd_acc;
            rd_err_q[0]  <= rd_acc & ~hit;
            rd_data_q[0] <= mem[idx];
            for (int i = 1; i < p_rd_latency; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_err_q[i]  <= rd_err_q[i-1];
                rd_data_q[i] <= rd_data_q[i-1];
            end
            if (rd_done) begin
                rd_hold_q <= rd_data_q[Last];
            end
        end
    end

    assign rd_done   = rd_vld_q[Last] & ~rd_err_q[Last];
    assign o_rd_data = rd_done ? rd_data_q[Last] : rd_hold_q;
    assign o_ack     = wr_ack_q | rd_vld_q[Last];
    assign o_err     = wr_err_q | rd_err_q[Last];
    assign o_busy    = ~ready;

endmodule

// File: tb/tb_soc_ram_dmem_pl.sv
// Directed bench for soc_ram_dmem_pl: 64-bit words, 16-word depth, read latency 3, clear sweep on.
module tb_soc_ram_dmem_pl;

    localparam logic [63:0] Init = 64'h0123_4567_89ab_cdef;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:3] addr = '0;
    logic [7:0]  be = '0;
    logic        wr_en = 1'b0;
    logic [63:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [63:0] rd_data;
    logic        busy, ack, err;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_rd;
    int n;
    logic ack_seen;

    soc_ram_dmem_pl #(
        .p_addr_base     (32'h1000_0000),
        .p_addr_mask     (32'hffff_f000),
        .p_data_width    (64),
        .p_depth_pw2     (4),
        .p_rd_latency    (3),
        .p_clear_on_reset(1'b1),
        .p_init_val      (Init)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_addr   (addr),
        .i_be     (be),
        .i_wr_en  (wr_en),
        .i_wr_data(wr_data),
        .i_rd_en  (rd_en),
        .o_rd_data(rd_data),
        .o_busy   (busy),
        .o_ack    (ack),
        .o_err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:3] wa(input logic [31:0] a);
        return a[31:3];
    endfunction

    // Single write; ack must arrive exactly one cycle later.
    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] b,
                      input logic exp_err, input string tag);
        addr = wa(a); wr_data = d; be = b; wr_en = 1'b1;
        tick();
        wr_en = 1'b0; be = '0;
        chk({tag, " wr ack"}, 64'(ack), 64'd1);
        chk({tag, " wr err"}, 64'(err), 64'(exp_err));
    endtask

    // Single read; ack three cycles after acceptance.
    task automatic rd(input logic [31:0] a, input logic [63:0] exp, input logic exp_err,
                      input string tag);
        addr = wa(a); rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, " rd early ack"}, 64'(ack), 64'd0);
        tick();
        tick();
        chk({tag, " rd ack"}, 64'(ack), 64'd1);
        chk({tag, " rd err"}, 64'(err), 64'(exp_err));
        chk({tag, " rd data"}, rd_data, exp);
        last_rd = rd_data;
    endtask

    // Counts busy cycles of a sweep (entered after the RST cycle), noting any ack meanwhile.
    task automatic sweep(output int cnt, output logic seen);
        cnt = 0;
        seen = 1'b0;
        while (busy && cnt < 40) begin
            tick();
            seen = seen | ack;
            cnt++;
        end
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst busy", 64'(busy), 64'd1);
        chk("rst ack", 64'(ack), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst rd_data", rd_data, 64'd0);
        tick();
        tick();

        // T1/T4: release; requests during sweep are ignored
        rst_n = 1'b1;
        addr = wa(32'h1000_0010);
        rd_en = 1'b1;
        tick();
        chk("clear busy", 64'(busy), 64'd1);
        sweep(n, ack_seen);
        rd_en = 1'b0;
        chk("sweep len", 64'(n), 64'd16);
        chk("ready busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_seen = ack_seen | ack;
        end
        chk("clear no ack", 64'(ack_seen), 64'd0);
        for (int i = 0; i < 16; i++) begin
            rd(32'h1000_0000 + 32'(i * 8), Init, 1'b0, "t1");
        end

        // T2: byte-enabled merge
        wr(32'h1000_0008, 64'h1122_3344_5566_7788, 8'hff, 1'b0, "t2a");
        wr(32'h1000_0008, 64'hffff_ffff_ffff_ffaa, 8'h01, 1'b0, "t2b");
        wr(32'h1000_0008, 64'h0, 8'h00, 1'b0, "t2c");
        rd(32'h1000_0008, 64'h1122_3344_5566_77aa, 1'b0, "t2");

        // T3: back-to-back reads at latency 3
        for (int i = 0; i < 4; i++) begin
            wr(32'h1000_0020 + 32'(i * 8), 64'hc0de_0000_0000_0000 + 64'(i), 8'hff, 1'b0, "t3w");
        end
        addr = wa(32'h1000_0020); rd_en = 1'b1;
        tick();
        chk("t3 c1 ack", 64'(ack), 64'd0);
        addr = wa(32'h1000_0028);
        tick();
        chk("t3 c2 ack", 64'(ack), 64'd0);
        addr = wa(32'h1000_0030);
        tick();
        chk("t3 r0 ack", 64'(ack), 64'd1);
        chk("t3 r0 data", rd_data, 64'hc0de_0000_0000_0000);
        addr = wa(32'h1000_0038);
        tick();
        rd_en = 1'b0;
        chk("t3 r1 ack", 64'(ack), 64'd1);
        chk("t3 r1 data", rd_data, 64'hc0de_0000_0000_0001);
        tick();
        chk("t3 r2 ack", 64'(ack), 64'd1);
        chk("t3 r2 data", rd_data, 64'hc0de_0000_0000_0002);
        tick();
        chk("t3 r3 ack", 64'(ack), 64'd1);
        chk("t3 r3 data", rd_data, 64'hc0de_0000_0000_0003);
        tick();
        chk("t3 idle ack", 64'(ack), 64'd0);
        chk("t3 hold data", rd_data, 64'hc0de_0000_0000_0003);
        last_rd = 64'hc0de_0000_0000_0003;

        // T4: region misses
        rd(32'h2000_0000, last_rd, 1'b1, "t4 rd miss");
        wr(32'h2000_0000, 64'hdead, 8'hff, 1'b1, "t4 wr miss");

        // T5: write/read collision, then read-after-write
        addr = wa(32'h1000_0004); wr_data = 64'h5555_aaaa_1234_5678; be = 8'hff;
        wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; be = '0;
        chk("t5 ack", 64'(ack), 64'd1);
        chk("t5 err", 64'(err), 64'd1);
        tick();
        rd_en = 1'b0;
        chk("t5 c1 ack", 64'(ack), 64'd0);
        tick();
        chk("t5 dropped rd", 64'(ack), 64'd0);
        tick();
        chk("t5 raw ack", 64'(ack), 64'd1);
        chk("t5 raw err", 64'(err), 64'd0);
        chk("t5 raw data", rd_data, 64'h5555_aaaa_1234_5678);

        // T6: reset mid-read-pipeline, then mid-sweep
        addr = wa(32'h1000_0008); rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6 busy", 64'(busy), 64'd1);
        chk("t6 ack", 64'(ack), 64'd0);
        chk("t6 err", 64'(err), 64'd0);
        chk("t6 rd_data", rd_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        ack_seen = ack;
        for (int i = 0; i < 5; i++) begin
            tick();
            ack_seen = ack_seen | ack;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("t6 sweep rst busy", 64'(busy), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        sweep(n, ack_seen);
        chk("t6 sweep len", 64'(n), 64'd16);
        chk("t6 no stale ack", 64'(ack_seen), 64'd0);
        rd(32'h1000_0008, Init, 1'b0, "t6 reclr1");
        rd(32'h1000_0000, Init, 1'b0, "t6 reclr0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
